// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma character front end.
// Holds widths, ASCII bounds, the sequencer state enum and the letter test.
package enigma_pkg;

  localparam int SETTING_W = 2;
  localparam int CHAR_W    = 8;

  localparam logic [CHAR_W-1:0] ASCII_A = 8'h41;
  localparam logic [CHAR_W-1:0] ASCII_Z = 8'h5A;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic is_letter(input logic [CHAR_W-1:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/enigma_key_sched.sv
// Rotating key schedule: holds KEY_LEN settings and an index that steps per letter.
// Latency: setting is combinational from the index (a same-cycle load exposes new entry 0).
// Backpressure: none; the caller only asserts step on an accepted letter.
module enigma_key_sched
  import enigma_pkg::*;
#(
  parameter int KEY_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [SETTING_W*KEY_LEN-1:0] load_data,
  input  logic                         step,
  input  logic                         clear,
  output logic [SETTING_W-1:0]         setting
);

  localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  logic [SETTING_W*KEY_LEN-1:0] key_q;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             idx_base;
  logic [IDX_W-1:0]             idx_d;

  // A load restarts the schedule, so a step in the same cycle advances from entry 0.
  always_comb begin
    idx_base = load ? '0 : idx_q;
    idx_d    = idx_base;
    if (step) begin
      idx_d = (idx_base == IDX_W'(KEY_LEN - 1)) ? '0 : idx_base + 1'b1;
    end
    if (clear) begin
      idx_d = '0;
    end
  end

  always_comb begin
    setting = key_q[int'(idx_q)*SETTING_W +: SETTING_W];
    if (load) begin
      setting = load_data[SETTING_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      idx_q <= '0;
    end else begin
      if (load) begin
        key_q <= load_data;
      end
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/enigma_char_sequencer.sv
// Tags each ASCII letter with a key-schedule setting; non-letters bypass. Optional: LOWERCASE_FOLD_EN.
// Latency: 1 cycle through a single output register.
// Backpressure: s_ready = !m_valid | m_ready; output beat held stable while stalled.
module enigma_char_sequencer
  import enigma_pkg::*;
#(
  parameter int KEY_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_load,
  input  logic [SETTING_W*KEY_LEN-1:0] key_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHAR_W-1:0]            s_char,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CHAR_W-1:0]            m_char,
  output logic [SETTING_W-1:0]         m_setting,
  output logic                         m_bypass,
  output logic                         m_last,
  output logic [CNT_W-1:0]             letter_cnt,
  output logic                         key_err
);

  state_t                state_q;
  state_t                state_d;
  logic                  load_ok;
  logic                  key_err_d;
  logic                  xfer;
  logic                  letter;
  logic [CHAR_W-1:0]     char_eff;
  logic [SETTING_W-1:0]  cur_setting;
  logic                  cnt_clr_q;
  logic [CNT_W-1:0]      cnt_base;
  logic [CNT_W-1:0]      cnt_d;

  assign s_ready = !m_valid || m_ready;
  assign xfer    = s_valid && s_ready;

`ifdef LOWERCASE_FOLD_EN
  always_comb begin
    char_eff = s_char;
    if ((s_char >= 8'h61) && (s_char <= 8'h7A)) begin
      char_eff = s_char & 8'hDF;
    end
  end
`else
  always_comb begin
    char_eff = s_char;
  end
`endif

  assign letter = is_letter(char_eff);

  always_comb begin
    state_d   = state_q;
    load_ok   = 1'b0;
    key_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        load_ok = key_load;
        if (xfer && !s_last) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        key_err_d = key_load;
        if (xfer && s_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  enigma_key_sched #(
    .KEY_LEN (KEY_LEN)
  ) u_key_sched (
    .clk       (clk),
    .rst       (rst),
    .load      (load_ok),
    .load_data (key_data),
    .step      (xfer && letter),
    .clear     (xfer && s_last),
    .setting   (cur_setting)
  );

  // The count of a finished message stays visible alongside its last beat, then clears.
  always_comb begin
    cnt_base = cnt_clr_q ? '0 : letter_cnt;
    cnt_d    = cnt_base;
    if (xfer && letter && (cnt_base != {CNT_W{1'b1}})) begin
      cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      key_err    <= 1'b0;
      letter_cnt <= '0;
      cnt_clr_q  <= 1'b0;
      m_valid    <= 1'b0;
      m_char     <= '0;
      m_setting  <= '0;
      m_bypass   <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_err    <= key_err_d;
      letter_cnt <= cnt_d;
      cnt_clr_q  <= xfer && s_last;
      if (xfer) begin
        m_valid   <= 1'b1;
        m_char    <= char_eff;
        m_setting <= letter ? cur_setting : '0;
        m_bypass  <= !letter;
        m_last    <= s_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enigma_char_sequencer.sv
// Directed bench for enigma_char_sequencer with hand-computed expectations.
module tb_enigma_char_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_load;
  logic [7:0]  key_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_char;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_char;
  logic [1:0]  m_setting;
  logic        m_bypass;
  logic        m_last;
  logic [15:0] letter_cnt;
  logic        key_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enigma_char_sequencer #(
    .KEY_LEN (4),
    .CNT_W   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .key_data   (key_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_char     (s_char),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_char     (m_char),
    .m_setting  (m_setting),
    .m_bypass   (m_bypass),
    .m_last     (m_last),
    .letter_cnt (letter_cnt),
    .key_err    (key_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic last);
    s_valid = 1'b1;
    s_char  = c;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] c, input logic [1:0] set,
                      input logic byp, input logic last);
    chk({tag, ".valid"},   32'(m_valid),   32'd1);
    chk({tag, ".char"},    32'(m_char),    32'(c));
    chk({tag, ".setting"}, 32'(m_setting), 32'(set));
    chk({tag, ".bypass"},  32'(m_bypass),  32'(byp));
    chk({tag, ".last"},    32'(m_last),    32'(last));
  endtask

  initial begin
    rst      = 1'b1;
    key_load = 1'b0;
    key_data = 8'h00;
    s_valid  = 1'b0;
    s_char   = 8'h00;
    s_last   = 1'b0;
    m_ready  = 1'b1;
    tick();
    tick();
    chk("rst.m_valid", 32'(m_valid), 32'd0);
    chk("rst.m_char", 32'(m_char), 32'd0);
    chk("rst.m_setting", 32'(m_setting), 32'd0);
    chk("rst.m_bypass", 32'(m_bypass), 32'd0);
    chk("rst.m_last", 32'(m_last), 32'd0);
    chk("rst.cnt", 32'(letter_cnt), 32'd0);
    chk("rst.key_err", 32'(key_err), 32'd0);
    chk("rst.s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    tick();

    // 1: "ABCDE" with key 3,2,1,0 (entry 0 = 0); load coincides with the first beat
    key_load = 1'b1;
    key_data = 8'b11_10_01_00;
    send(8'h41, 1'b0);
    key_load = 1'b0;
    beat("t1.A", 8'h41, 2'd0, 1'b0, 1'b0);
    chk("t1.cntA", 32'(letter_cnt), 32'd1);
    send(8'h42, 1'b0);
    beat("t1.B", 8'h42, 2'd1, 1'b0, 1'b0);
    send(8'h43, 1'b0);
    beat("t1.C", 8'h43, 2'd2, 1'b0, 1'b0);
    send(8'h44, 1'b0);
    beat("t1.D", 8'h44, 2'd3, 1'b0, 1'b0);
    send(8'h45, 1'b1);
    beat("t1.E", 8'h45, 2'd0, 1'b0, 1'b1);
    chk("t1.cnt5", 32'(letter_cnt), 32'd5);
    tick();
    chk("t1.idle_valid", 32'(m_valid), 32'd0);
    chk("t1.cnt_clr", 32'(letter_cnt), 32'd0);

    // 2: "A @[B" with boundary non-letters; reload in IDLE must not raise key_err
    key_load = 1'b1;
    send(8'h41, 1'b0);
    key_load = 1'b0;
    chk("t2.idle_load_no_err", 32'(key_err), 32'd0);
    beat("t2.A", 8'h41, 2'd0, 1'b0, 1'b0);
    send(8'h20, 1'b0);
    beat("t2.sp", 8'h20, 2'd0, 1'b1, 1'b0);
    chk("t2.cnt_sp", 32'(letter_cnt), 32'd1);
    send(8'h40, 1'b0);
    beat("t2.at", 8'h40, 2'd0, 1'b1, 1'b0);
    send(8'h5B, 1'b0);
    beat("t2.brk", 8'h5B, 2'd0, 1'b1, 1'b0);
    send(8'h42, 1'b1);
    beat("t2.B", 8'h42, 2'd1, 1'b0, 1'b1);
    chk("t2.cnt", 32'(letter_cnt), 32'd2);
    tick();

    // 3: stall for 3 cycles with the next character waiting
    m_ready = 1'b0;
    send(8'h43, 1'b0);
    beat("t3.C", 8'h43, 2'd0, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_char  = 8'h44;
    for (int i = 0; i < 3; i++) begin
      chk("t3.s_ready_stall", 32'(s_ready), 32'd0);
      tick();
      beat("t3.hold", 8'h43, 2'd0, 1'b0, 1'b0);
    end
    m_ready = 1'b1;
    #1;
    chk("t3.s_ready_rel", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    beat("t3.D", 8'h44, 2'd1, 1'b0, 1'b0);
    send(8'h45, 1'b1);
    beat("t3.E", 8'h45, 2'd2, 1'b0, 1'b1);
    chk("t3.cnt", 32'(letter_cnt), 32'd3);
    tick();

    // 4: key_load mid-message is refused and flagged
    send(8'h41, 1'b0);
    beat("t4.A", 8'h41, 2'd0, 1'b0, 1'b0);
    key_load = 1'b1;
    key_data = 8'h00;
    send(8'h42, 1'b0);
    key_load = 1'b0;
    chk("t4.key_err", 32'(key_err), 32'd1);
    beat("t4.B", 8'h42, 2'd1, 1'b0, 1'b0);
    send(8'h43, 1'b1);
    chk("t4.key_err_pulse", 32'(key_err), 32'd0);
    beat("t4.C", 8'h43, 2'd2, 1'b0, 1'b1);
    tick();
    send(8'h42, 1'b0);
    beat("t4.m2B", 8'h42, 2'd0, 1'b0, 1'b0);
    send(8'h43, 1'b1);
    beat("t4.m2C", 8'h43, 2'd1, 1'b0, 1'b1);
    tick();
    key_load = 1'b1;
    key_data = 8'b00_01_10_11;
    send(8'h41, 1'b1);
    key_load = 1'b0;
    chk("t4.reload_no_err", 32'(key_err), 32'd0);
    beat("t4.reload", 8'h41, 2'd3, 1'b0, 1'b1);
    tick();

    // 5: reset with a stalled beat in the output register
    send(8'h41, 1'b0);
    beat("t5.A", 8'h41, 2'd3, 1'b0, 1'b0);
    send(8'h42, 1'b0);
    beat("t5.B", 8'h42, 2'd2, 1'b0, 1'b0);
    m_ready = 1'b0;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    chk("t5.m_valid", 32'(m_valid), 32'd0);
    chk("t5.cnt", 32'(letter_cnt), 32'd0);
    chk("t5.m_char", 32'(m_char), 32'd0);
    send(8'h41, 1'b0);
    beat("t5.freshA", 8'h41, 2'd0, 1'b0, 1'b0);
    chk("t5.cnt1", 32'(letter_cnt), 32'd1);
    send(8'h5A, 1'b1);
    beat("t5.Z", 8'h5A, 2'd0, 1'b0, 1'b1);
    tick();

    // 6: lowercase handling depends on the build
    key_load = 1'b1;
    key_data = 8'b11_10_01_00;
    send(8'h61, 1'b0);
    key_load = 1'b0;
`ifdef LOWERCASE_FOLD_EN
    beat("t6.a", 8'h41, 2'd0, 1'b0, 1'b0);
    send(8'h42, 1'b1);
    beat("t6.B", 8'h42, 2'd1, 1'b0, 1'b1);
`else
    beat("t6.a", 8'h61, 2'd0, 1'b1, 1'b0);
    send(8'h42, 1'b1);
    beat("t6.B", 8'h42, 2'd0, 1'b0, 1'b1);
`endif
    tick();
    chk("t6.end_valid", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
